regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of registers (power of two, >= 2); AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of combinational read ports.
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- raddr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN].
- we  in  NWR  per-port write enable.
- waddr  in  NWR*AW  write addresses; port j at [j*AW +: AW].
- wdata  in  NWR*XLEN  write data; port j at [j*XLEN +: XLEN].
- dump_req  in  1  start a full register dump (level, sampled in IDLE).
- dump_valid  out  1  dump_idx/dump_data valid.
- dump_ready  in  1  consumer accepts current dump beat.
- dump_idx  out  AW  register index of current beat.
- dump_data  out  XLEN  contents of register dump_idx.
- dump_busy  out  1  dump FSM not in IDLE.
- dump_done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-007 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-008 Write port j SHALL update register waddr[j] with wdata[j] on the posedge where we[j]=1 and rst=0.
REQ-009 Several write ports to the same nonzero address in one cycle: highest-numbered enabled port SHALL win.
REQ-010 Read port i SHALL combinationally return register raddr[i] contents (zero latency).
REQ-011 With BYPASS=1, if any enabled write port targets raddr[i] (nonzero) in the same cycle, rdata[i] SHALL return that write's wdata (REQ-009 priority); with BYPASS=0 it SHALL return the pre-write value.
REQ-012 Dump FSM states: IDLE, SEND, DONE.
REQ-013 IDLE: dump_valid=0, dump_busy=0; dump_req=1 at posedge -> SEND with dump_idx=0.
REQ-014 SEND: dump_valid=1, dump_busy=1, dump_data = current contents of register dump_idx (combinational, including bypass per REQ-011).
REQ-015 SEND with dump_ready=1: dump_idx<NREGS-1 -> dump_idx+1, stay SEND; dump_idx=NREGS-1 -> DONE.
REQ-016 SEND with dump_ready=0: dump_idx and state SHALL hold; dump_data SHALL track live register contents.
REQ-017 DONE: dump_done=1, dump_valid=0, dump_busy=1 for exactly one cycle, then IDLE; dump_req is ignored in DONE.
REQ-018 dump_req held high continuously SHALL start a new dump on the cycle after each return to IDLE.
REQ-019 Normal write and read ports SHALL operate unaffected during a dump; no stall.
REQ-020 dump_idx SHALL never wrap past NREGS-1; exactly NREGS beats per dump.

Reset
REQ-021 rst=1 at posedge SHALL clear all registers to 0 and force FSM to IDLE, dump_idx=0, dump_done=0, overriding simultaneous writes and dump_req.
REQ-022 Reset mid-dump SHALL abort with no dump_done pulse; the next dump restarts at index 0.
REQ-023 After reset all rdata outputs SHALL read 0 until the first write.

Verification
REQ-024 Write 0xDEADBEEF to r5 via port 0, next cycle raddr[0]=5 -> rdata[0]=0xDEADBEEF; write to r0 -> r0 reads 0.
REQ-025 Same cycle port0 writes r7=0x11, port1 writes r7=0x22, raddr[1]=7 -> BYPASS=1 rdata=0x22 same cycle, BYPASS=0 rdata=old value; next cycle r7=0x22.
REQ-026 Load rN=N*0x100 for all N, pulse dump_req, dump_ready=1 -> NREGS beats idx 0..NREGS-1 with data N*0x100 (r0=0), dump_done one cycle after last beat.
REQ-027 Dump with dump_ready toggling 1/0 every cycle -> no beat lost or duplicated, still exactly NREGS accepted beats.
REQ-028 Assert rst while dump_idx=10 -> next cycle dump_busy=0, all registers 0, no dump_done.
REQ-029 During dump, write r3=0xABCD before idx 3 accepted -> beat idx 3 carries 0xABCD.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file with hard-wired zero register, optional write-to-read
// forwarding, and a handshaked FSM that streams out every register in index order.
module regfile_mp #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                dump_req,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_busy,
  output logic                dump_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } dump_state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  dump_state_e     state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Current value of a register as seen this cycle; later write ports override earlier ones.
  function automatic logic [XLEN-1:0] read_reg(input logic [AW-1:0] addr);
    logic [XLEN-1:0] v;
    v = regs_q[addr];
    if (BYPASS != 0) begin
      for (int j = 0; j < NWR; j++) begin
        v = (we[j] && (waddr[j*AW +: AW] == addr)) ? wdata[j*XLEN +: XLEN] : v;
      end
    end else begin
      v = regs_q[addr];
    end
    return (addr == {AW{1'b0}}) ? {XLEN{1'b0}} : v;
  endfunction

  // Next register contents: ascending port order gives the highest enabled port priority.
  always_comb begin
    logic [AW-1:0] wa;
    wa     = {AW{1'b0}};
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      wa         = waddr[j*AW +: AW];
      regs_d[wa] = (we[j] && (wa != {AW{1'b0}})) ? wdata[j*XLEN +: XLEN] : regs_d[wa];
    end
    regs_d[0] = {XLEN{1'b0}};
  end

  // Read ports and dump data path.
  always_comb begin
    rdata = {NRD*XLEN{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      rdata[i*XLEN +: XLEN] = read_reg(raddr[i*AW +: AW]);
    end
    dump_data = read_reg(idx_q);
  end

  // Dump FSM next state; the status outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          state_d = S_SEND;
          idx_d   = {AW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State registers; reset wins over writes and dump requests alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '{default: {XLEN{1'b0}}};
      state_q <= S_IDLE;
      idx_q   <= {AW{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;
  assign dump_idx   = idx_q;

endmodule
